// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC definitions.
//   PORT_I / PORT_D : port identifiers for the instruction-fetch and load/store
//                     paths. They also serve as the bit indices into the
//                     two-bit request/grant vectors.
//   ADDR_W_DEF / DATA_W_DEF : default bus widths.
//   is_write()      : a data access is a store when any byte enable is set.
package soc_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // A non-zero byte mask marks a store; an all-zero mask is a read.
  function automatic logic is_write(input logic [DATA_W_DEF/8-1:0] wmask);
    return |wmask;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin picker (purely combinational).
//   req[1:0] : request vector, indexed by port (PORT_I = bit 0, PORT_D = bit 1)
//   last     : port that was granted most recently
//   gnt[1:0] : one-hot grant; all zero when nobody requests
// A lone requester always wins. On a conflict, the port that was not granted
// most recently wins.
module rr_pick2
  import soc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant selection from the request vector and the last winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PORT_I) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port (i_*) and
// the load/store port (d_*). At most one access is granted per cycle, chosen
// round-robin. Read data comes back one cycle later and is routed to the port
// that issued the access.
//   clk, resetn     : clock; asynchronous reset, active HIGH despite its name
//   i_req/i_addr    : fetch request  -> i_gnt, i_rvalid, i_rdata
//   d_req/d_addr/d_wmask/d_wdata : data request (wmask == 0 means read)
//                   -> d_gnt, d_rvalid (read data or store ack), d_rdata
//   mem_*           : memory port; mem_rdata arrives one cycle after mem_rd_en
//   busy            : a response is due this cycle
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned MASK_W = DATA_W / 8;

  logic [1:0]        pick_s;
  logic              d_wr_s;

  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              last_q,       last_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_port_q,  resp_port_d;
  logic              resp_wr_q,    resp_wr_d;
  logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

  rr_pick2 u_pick (
    .req  ({d_req, i_req}),
    .last (last_q),
    .gnt  (pick_s)
  );

  // Grants are masked while reset is held so that no access, in particular a
  // store, reaches the memory during the reset cycle.
  always_comb begin
    if (resetn) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end else begin
      i_gnt = pick_s[PORT_I];
      d_gnt = pick_s[PORT_D];
    end
  end

  assign d_wr_s = d_gnt & is_write(d_wmask);

  // Memory command. Without a grant, the address shadow keeps mem_addr stable.
  always_comb begin
    mem_addr  = addr_q;
    mem_rd_en = 1'b0;
    mem_wmask = {MASK_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (resetn) begin
      mem_addr = {ADDR_W{1'b0}};
    end else if (d_gnt) begin
      mem_addr = d_addr;
      if (d_wr_s) begin
        mem_wmask = d_wmask;
        mem_wdata = d_wdata;
      end else begin
        mem_rd_en = 1'b1;
      end
    end else if (i_gnt) begin
      mem_addr  = i_addr;
      mem_rd_en = 1'b1;
    end else begin
      mem_addr = addr_q;
    end
  end

  // Response routing. Each port's rdata shows mem_rdata while its response is
  // being delivered, and otherwise holds the last value it delivered.
  always_comb begin
    i_rvalid  = resp_valid_q & (resp_port_q == PORT_I);
    d_rvalid  = resp_valid_q & (resp_port_q == PORT_D);
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (i_rvalid) begin
      i_rdata_d = mem_rdata;
    end else begin
      i_rdata_d = i_rdata_q;
    end
    // A store acknowledge carries no data, so d_rdata keeps its old value.
    if (d_rvalid && !resp_wr_q) begin
      d_rdata_d = mem_rdata;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  assign i_rdata = i_rdata_d;
  assign d_rdata = d_rdata_d;
  assign busy    = resp_valid_q;

  // Next state for the arbitration history and the response tracker.
  always_comb begin
    addr_d       = mem_addr;
    resp_valid_d = i_gnt | d_gnt;
    resp_port_d  = d_gnt ? PORT_D : PORT_I;
    resp_wr_d    = d_wr_s;
    if (d_gnt) begin
      last_d = PORT_D;
    end else if (i_gnt) begin
      last_d = PORT_I;
    end else begin
      last_d = last_q;
    end
  end

  // State registers. Reset clears the pending response at once, so its rvalid
  // is never issued.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      addr_q       <= {ADDR_W{1'b0}};
      last_q       <= PORT_I;
      resp_valid_q <= 1'b0;
      resp_port_q  <= PORT_I;
      resp_wr_q    <= 1'b0;
      i_rdata_q    <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
    end else begin
      addr_q       <= addr_d;
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_wr_q    <= resp_wr_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter, with a small
// word-addressed memory model (one-cycle read latency, byte-masked writes)
// and hand-written sequences for reset in the middle of an access.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hold_viol = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read data, byte-lane writes.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // A request that was left ungranted must still be present next cycle.
  logic pend_i = 1'b0, pend_d = 1'b0;
  always @(posedge clk) begin
    if (!resetn && pend_i && !i_req) hold_viol <= hold_viol + 1;
    if (!resetn && pend_d && !d_req) hold_viol <= hold_viol + 1;
    pend_i <= !resetn && i_req && !i_gnt;
    pend_d <= !resetn && d_req && !d_gnt;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic [31:0] da; logic [3:0] dm; logic [31:0] dw;
    logic        eig; logic edg; logic eiv; logic edv;
    logic [31:0] eid; logic [31:0] edd; logic dcd;
    logic [31:0] ema; logic ere; logic [3:0] ewm; logic ebusy;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                              logic [3:0] dm, logic [31:0] dw, logic eig, logic edg,
                              logic eiv, logic edv, logic [31:0] eid, logic [31:0] edd,
                              logic dcd, logic [31:0] ema, logic ere, logic [3:0] ewm,
                              logic ebusy);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dm = dm; v.dw = dw;
    v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv;
    v.eid = eid; v.edd = edd; v.dcd = dcd;
    v.ema = ema; v.ere = ere; v.ewm = ewm; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dw);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wmask = dm; d_wdata = dw;
  endtask

  vec_t vecs [16];

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[1]   = 32'h00A08093;
    mem[2]   = 32'h11223344;
    mem[3]   = 32'h55667788;
    mem[100] = 32'h04030201;
    mem_rdata = 32'h0;

    //           ir i_addr  dr d_addr  wmask    wdata          ig dg iv dv i_rdata        d_rdata        dc mem_addr rd wm     busy
    vecs[0]  = mk(1, 32'd4,  0, 32'd0,   4'b0000, 32'h0,        1, 0, 0, 0, 32'h0,         32'h0,         0, 32'd4,   1, 4'b0, 0);
    vecs[1]  = mk(0, 32'd0,  0, 32'd0,   4'b0000, 32'h0,        0, 0, 1, 0, 32'h00A08093,  32'h0,         0, 32'd4,   0, 4'b0, 1);
    vecs[2]  = mk(1, 32'd8,  1, 32'd400, 4'b0000, 32'h0,        0, 1, 0, 0, 32'h00A08093,  32'h0,         0, 32'd400, 1, 4'b0, 0);
    vecs[3]  = mk(1, 32'd8,  1, 32'd400, 4'b0000, 32'h0,        1, 0, 0, 1, 32'h00A08093,  32'h04030201,  0, 32'd8,   1, 4'b0, 1);
    vecs[4]  = mk(1, 32'd8,  1, 32'd400, 4'b0000, 32'h0,        0, 1, 1, 0, 32'h11223344,  32'h04030201,  0, 32'd400, 1, 4'b0, 1);
    vecs[5]  = mk(1, 32'd8,  1, 32'd400, 4'b0000, 32'h0,        1, 0, 0, 1, 32'h11223344,  32'h04030201,  0, 32'd8,   1, 4'b0, 1);
    vecs[6]  = mk(0, 32'd0,  1, 32'd400, 4'b0000, 32'h0,        0, 1, 1, 0, 32'h11223344,  32'h04030201,  0, 32'd400, 1, 4'b0, 1);
    vecs[7]  = mk(0, 32'd0,  1, 32'd400, 4'b0010, 32'h0000AA00, 0, 1, 0, 1, 32'h11223344,  32'h04030201,  0, 32'd400, 0, 4'b0010, 1);
    vecs[8]  = mk(0, 32'd0,  1, 32'd400, 4'b0000, 32'h0,        0, 1, 0, 1, 32'h11223344,  32'h0,         1, 32'd400, 1, 4'b0, 1);
    vecs[9]  = mk(0, 32'd0,  0, 32'd0,   4'b0000, 32'h0,        0, 0, 0, 1, 32'h11223344,  32'h0403AA01,  0, 32'd400, 0, 4'b0, 1);
    vecs[10] = mk(0, 32'd0,  0, 32'd0,   4'b0000, 32'h0,        0, 0, 0, 0, 32'h11223344,  32'h0403AA01,  0, 32'd400, 0, 4'b0, 0);
    vecs[11] = mk(1, 32'd4,  0, 32'd0,   4'b0000, 32'h0,        1, 0, 0, 0, 32'h11223344,  32'h0403AA01,  0, 32'd4,   1, 4'b0, 0);
    vecs[12] = mk(1, 32'd8,  0, 32'd0,   4'b0000, 32'h0,        1, 0, 1, 0, 32'h00A08093,  32'h0403AA01,  0, 32'd8,   1, 4'b0, 1);
    vecs[13] = mk(1, 32'd12, 0, 32'd0,   4'b0000, 32'h0,        1, 0, 1, 0, 32'h11223344,  32'h0403AA01,  0, 32'd12,  1, 4'b0, 1);
    vecs[14] = mk(0, 32'd0,  0, 32'd0,   4'b0000, 32'h0,        0, 0, 1, 0, 32'h55667788,  32'h0403AA01,  0, 32'd12,  0, 4'b0, 1);
    vecs[15] = mk(0, 32'd0,  0, 32'd0,   4'b0000, 32'h0,        0, 0, 0, 0, 32'h55667788,  32'h0403AA01,  0, 32'd12,  0, 4'b0, 0);

    // Reset state, with a store request present: it must not reach memory.
    resetn = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 32'd400, 4'b1111, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 4'b0000, 32'h0);

    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      drive(vecs[n].ir, vecs[n].ia, vecs[n].dr, vecs[n].da, vecs[n].dm, vecs[n].dw);
      @(negedge clk);
      chk($sformatf("v%0d_i_gnt", n), {31'd0, i_gnt}, {31'd0, vecs[n].eig});
      chk($sformatf("v%0d_d_gnt", n), {31'd0, d_gnt}, {31'd0, vecs[n].edg});
      chk($sformatf("v%0d_i_rvalid", n), {31'd0, i_rvalid}, {31'd0, vecs[n].eiv});
      chk($sformatf("v%0d_d_rvalid", n), {31'd0, d_rvalid}, {31'd0, vecs[n].edv});
      chk($sformatf("v%0d_i_rdata", n), i_rdata, vecs[n].eid);
      if (!vecs[n].dcd) chk($sformatf("v%0d_d_rdata", n), d_rdata, vecs[n].edd);
      chk($sformatf("v%0d_mem_addr", n), mem_addr, vecs[n].ema);
      chk($sformatf("v%0d_rd_en", n), {31'd0, mem_rd_en}, {31'd0, vecs[n].ere});
      chk($sformatf("v%0d_wmask", n), {28'd0, mem_wmask}, {28'd0, vecs[n].ewm});
      if (vecs[n].ewm != 4'b0000) chk($sformatf("v%0d_wdata", n), mem_wdata, vecs[n].dw);
      chk($sformatf("v%0d_busy", n), {31'd0, busy}, {31'd0, vecs[n].ebusy});
    end

    // Data grant leaves last winner = data; a reset must restore it to fetch.
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 1'b1, 32'd400, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sa_d_gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 32'd8, 4'b1111, 32'hCAFEF00D);
    #1;
    chk("sa_busy_clr", {31'd0, busy}, 32'd0);
    chk("sa_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("sa_wr_suppress", {28'd0, mem_wmask}, 32'd0);
    chk("sa_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(1'b1, 32'd4, 1'b1, 32'd400, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sa_conflict_d", {30'd0, d_gnt, i_gnt}, 32'd2);
    chk("sa_mem_addr2", mem_addr, 32'd400);
    @(posedge clk); #1;
    drive(1'b1, 32'd4, 1'b0, 32'd0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sa_i_next", {30'd0, d_gnt, i_gnt}, 32'd1);
    chk("sa_d_resp", d_rdata, 32'h0403AA01);

    // Reset the cycle after a fetch grant: the fetch response is dropped.
    @(posedge clk); #1;
    drive(1'b1, 32'd8, 1'b0, 32'd0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sb_i_gnt", {31'd0, i_gnt}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 4'b0000, 32'h0);
    #1;
    chk("sb_no_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("sb_busy_clr", {31'd0, busy}, 32'd0);
    chk("sb_i_rdata_rst", i_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("sb_no_late_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 32'd4, 1'b1, 32'd400, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sb_conflict_d", {30'd0, d_gnt, i_gnt}, 32'd2);
    @(posedge clk); #1;
    drive(1'b1, 32'd4, 1'b0, 32'd0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sb_i_after", {30'd0, d_gnt, i_gnt}, 32'd1);
    chk("sb_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 4'b0000, 32'h0);
    @(negedge clk);
    chk("sb_i_rdata", i_rdata, 32'h00A08093);
    chk("req_hold", hold_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port instruction/data `Memory` between the processor's instruction-fetch path and its load/store path. It sits between `Processor` and `Memory` inside `SOC`. It grants one access per cycle using round-robin priority. It routes the one-cycle-latency read data back to the port that issued the access. Byte-masked writes pass through on the data port, so stores can be added to the core.

## Interface
- `ADDR_W`, 32, address width of both requester ports and the memory port
- `DATA_W`, 32, data width; byte-mask width is `DATA_W/8`
- `clk`  in  1  system clock (post-Clockworks slow clock)
- `resetn`  in  1  asynchronous, active-high reset (name kept from the SOC wiring; asserted = 1)
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  ADDR_W  fetch byte address
- `i_gnt`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  fetch data valid
- `i_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request; held with `d_addr`/`d_wmask`/`d_wdata` until `d_gnt`
- `d_addr`  in  ADDR_W  data byte address
- `d_wmask`  in  DATA_W/8  byte write enables; 0 = read
- `d_wdata`  in  DATA_W  store data, already lane-aligned by the core
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data response (read data or store acknowledge)
- `d_rdata`  out  DATA_W  data read data
- `mem_addr`  out  ADDR_W  address to memory
- `mem_rd_en`  out  1  memory read strobe
- `mem_wmask`  out  DATA_W/8  memory byte write enables
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, registered one cycle after `mem_rd_en`
- `busy`  out  1  a response is outstanding this cycle

## Operation
- Arbitration is combinational in the request cycle. At most one grant per cycle.
- Only one port requests: that port is granted.
- Both ports request: the port not granted most recently wins. `last_port` updates on every grant.
- After reset `last_port` = fetch, so the first conflict goes to data.
- On grant, the winner's address is driven onto `mem_addr`.
  - Read (fetch, or data with `d_wmask`==0): `mem_rd_en`=1, `mem_wmask`=0.
  - Write (data with `d_wmask`!=0): `mem_rd_en`=0, `mem_wmask`=`d_wmask`, `mem_wdata`=`d_wdata`.
- With no grant: `mem_rd_en`=0, `mem_wmask`=0, and `mem_addr` holds its last value (registered shadow) so the memory sees a stable address.
- Response register: `resp_valid`, `resp_port`, set in the grant cycle.
- Next cycle, `x_rvalid`=1 for the `resp_port` port only.
  - `x_rdata`=`mem_rdata` for reads.
  - `d_rdata` is undefined and `d_rvalid` still pulses for a store acknowledge.
- `rdata` of the non-addressed port is held at its last delivered value.
- `busy` = `resp_valid`.
- Address bits [1:0] pass through unchanged; the memory ignores them. Alignment and byte extraction are the requester's job.
- A requester lowering `req` before `gnt` is illegal. A bench assertion flags it.

## Timing
- Request cycle N with grant: memory strobe in cycle N, `rvalid` in cycle N+1. Read latency is 1 cycle after grant.
- Back-to-back grants every cycle are allowed; each response is delivered exactly one cycle after its grant.
- With both ports continuously requesting, grants strictly alternate D, I, D, I, …
- Reset values: all `gnt`/`rvalid`/`mem_rd_en` = 0, `mem_wmask` = 0, `mem_addr` = 0, `rdata` = 0, `busy` = 0, `last_port` = fetch.
- Reset asserted mid-access: `resp_valid` clears immediately and the pending `rvalid` is never issued. A write strobed in the same cycle as reset assertion is suppressed (outputs forced to 0).
- Same-cycle `i_req` and `d_req` with a response outstanding: arbitration proceeds normally; the outstanding response does not stall new grants.

## Structure
- Shared package `soc_pkg`: `PORT_I`=1'b0, `PORT_D`=1'b1, and the default widths.
- One sub-module `rr_pick2` (two-requester round-robin: inputs `req[1:0]`, `last`; outputs one-hot `gnt[1:0]`). The response and `last_port` registers stay in `mem_arbiter`.

## Test plan
- Reset, then `i_req`=1, `i_addr`=4 with MEM[1]=32'h00A08093 -> `i_gnt` in the same cycle, `i_rvalid`=1 with `i_rdata`=32'h00A08093 one cycle later, `d_rvalid`=0.
- Both ports request constantly (`i_addr`=8, `d_addr`=400, MEM[100]=32'h04030201) -> grants D,I,D,I; `d_rdata`=32'h04030201, `i_rdata`=MEM[2] on alternate cycles.
- `d_req` with `d_wmask`=4'b0010, `d_addr`=400, `d_wdata`=32'h0000AA00, then read addr 400 -> `d_rvalid` ack, then `d_rdata`=32'h0403AA01.
- Reset asserted the cycle after a fetch grant -> no `i_rvalid` follows, `busy`=0 immediately, and after release the next conflict is granted to data.
- Fetch-only stream at addrs 4, 8, 12 for 3 cycles -> three grants in consecutive cycles and three `i_rvalid` pulses offset by one cycle, data port silent.
- Idle cycles -> `mem_rd_en`=0, `mem_wmask`=0, `mem_addr` unchanged from the last grant.
